// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - state encoding and width limits for the bit-serial subtractor
package serial_sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor cell: d = a - b - bin
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic borrow
);

    assign d      = a ^ b ^ bin;
    assign borrow = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// rtl/serial_subtractor_ctrl.sv - bit-serial a - b - bin over WIDTH cycles, LSB first
// Optional feature: SERIAL_SUB_SAT_EN clamps d to zero when the final borrow is set.
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_chk
            $error("serial_subtractor_ctrl: WIDTH out of range");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic             r_bor;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_d;
    logic             r_borrow;
    logic             w_diff;
    logic             w_bor_out;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    full_subtractor u_cell (
        .a      (r_a_sr[0]),
        .b      (r_b_sr[0]),
        .bin    (r_bor),
        .d      (w_diff),
        .borrow (w_bor_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid)                 w_next = ST_RUN;
                ST_RUN:  if (w_last)                   w_next = ST_DONE;
                ST_DONE: if (r_out_valid && out_ready) w_next = ST_IDLE;
                default:                               w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (r_state == ST_IDLE);
        busy     = (r_state == ST_RUN) || (r_state == ST_DONE);
    end

    // DONE spends one cycle publishing the result before out_valid rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_res       <= '0;
            r_bor       <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_d         <= '0;
            r_borrow    <= 1'b0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a_sr <= a;
                        r_b_sr <= b;
                        r_bor  <= bin;
                        r_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_res  <= {w_diff, r_res[WIDTH-1:1]};
                    r_bor  <= w_bor_out;
                    if (!w_last) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_borrow    <= r_bor;
`ifdef SERIAL_SUB_SAT_EN
                        r_d         <= r_bor ? '0 : r_res;
`else
                        r_d         <= r_res;
`endif
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign d         = r_d;
    assign borrow    = r_borrow;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb/tb_serial_subtractor_ctrl.sv - randomized self-checking bench for serial_subtractor_ctrl
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] d;
    logic         borrow;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .borrow    (borrow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic int ref_borrow(input int ai, input int bi_, input int ci);
        return (ai < bi_ + ci) ? 1 : 0;
    endfunction

    function automatic int ref_diff(input int ai, input int bi_, input int ci);
        int r;
        r = ai - bi_ - ci;
        if (r < 0) r += (1 << W);
`ifdef SERIAL_SUB_SAT_EN
        if (ai < bi_ + ci) r = 0;
`endif
        return r;
    endfunction

    task automatic do_op(input int ai, input int bi_, input int ci, input int hold);
        int lat;
        int ed;
        int eb;
        ed = ref_diff(ai, bi_, ci);
        eb = ref_borrow(ai, bi_, ci);
        @(negedge clk);
        a         = W'(ai);
        b         = W'(bi_);
        bin       = ci[0];
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("in_ready_run", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, W + 1);
        chk("d", d, ed);
        chk("borrow", borrow, eb);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = W'($urandom);
            @(posedge clk); #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_d", d, ed);
            chk("hold_borrow", borrow, eb);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
        chk("d_kept", d, ed);
        chk("borrow_kept", borrow, eb);
    endtask

    initial begin
        int seen;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_d", d, 0);
        chk("rst_borrow", borrow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(100, 37, 0, 0);
        do_op(5, 9, 0, 0);
        do_op(0, 0, 1, 0);
        do_op(255, 255, 0, 0);
        do_op(77, 200, 1, 5);

        // clear together with in_valid in IDLE: operands must not be taken
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; a = 8'd1; b = 8'd2;
        @(posedge clk); #1;
        chk("clear_idle_in_ready", in_ready, 1);
        chk("clear_idle_busy", busy, 0);
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;

        // clear mid-RUN at cnt=3
        @(negedge clk);
        a = 8'd50; b = 8'd20; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear_run_in_ready", in_ready, 1);
        chk("clear_run_busy", busy, 0);
        chk("clear_run_out_valid", out_valid, 0);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("clear_no_out_valid", seen, 0);
        out_ready = 1'b0;
        do_op(10, 3, 0, 0);

        // async reset mid-RUN
        @(negedge clk);
        a = 8'd90; b = 8'd10; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_d", d, 0);
        chk("arst_borrow", borrow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(200, 199, 1, 0);

        for (int k = 0; k < 25; k++) begin
            do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
